// File: rtl/reg_alu_pkg.sv
// Shared definitions for the reg_alu instruction sequencer: widths, instruction
// field positions, instruction kinds and FSM state encodings.
package reg_alu_pkg;

  localparam int DW_DEF  = 16;
  localparam int AW_DEF  = 3;
  localparam int OPW_DEF = 2;

  localparam int KIND_HI = 15;
  localparam int KIND_LO = 14;
  localparam int OP_HI   = 13;
  localparam int OP_LO   = 12;
  localparam int RA_HI   = 11;
  localparam int RA_LO   = 9;
  localparam int RB_HI   = 8;
  localparam int RB_LO   = 6;
  localparam int RD_HI   = 5;
  localparam int RD_LO   = 3;

  typedef enum logic [1:0] {
    KIND_LOADI = 2'b00,
    KIND_ALU   = 2'b01,
    KIND_READ  = 2'b10,
    KIND_NOP   = 2'b11
  } kind_t;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_IMM  = 2'b01,
    S_EXEC = 2'b10,
    S_RSP  = 2'b11
  } state_t;

endpackage

// File: rtl/reg_alu_seq_decode.sv
// Combinational split of an instruction word into kind and operand fields.
module reg_alu_seq_decode
  import reg_alu_pkg::*;
(
  input  logic [DW_DEF-1:0]  word,
  output kind_t              kind,
  output logic [OPW_DEF-1:0] op,
  output logic [AW_DEF-1:0]  ra,
  output logic [AW_DEF-1:0]  rb,
  output logic [AW_DEF-1:0]  rd
);

  assign kind = kind_t'(word[KIND_HI:KIND_LO]);
  assign op   = word[OP_HI:OP_LO];
  assign ra   = word[RA_HI:RA_LO];
  assign rb   = word[RB_HI:RB_LO];
  assign rd   = word[RD_HI:RD_LO];

  // Low bits are reserved in every instruction kind.
  logic unused_reserved;
  assign unused_reserved = ^word[RD_LO-1:0];

endmodule

// File: rtl/reg_alu_seq.sv
// Instruction sequencer driving the reg_alu control/data interface from a
// valid/ready instruction stream, with a read-response channel.
//
// state | meaning
// IDLE  | waiting for an instruction word
// IMM   | LOADI accepted, waiting for its immediate word
// EXEC  | one cycle with registered reg_alu controls applied
// RSP   | READ data captured, waiting for rsp_ready
module reg_alu_seq
  import reg_alu_pkg::*;
#(
  parameter int DW  = DW_DEF,
  parameter int AW  = AW_DEF,
  parameter int OPW = OPW_DEF
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [DW-1:0]  in_data,
  output logic           sel,
  output logic           wr,
  output logic [OPW-1:0] op,
  output logic [AW-1:0]  rd_addr_a,
  output logic [AW-1:0]  rd_addr_b,
  output logic [AW-1:0]  wr_addr,
  output logic [DW-1:0]  d_in,
  input  logic [DW-1:0]  d_out_a,
  input  logic [DW-1:0]  d_out_b,
  input  logic           cout,
  output logic           rsp_valid,
  input  logic           rsp_ready,
  output logic [DW-1:0]  rsp_a,
  output logic [DW-1:0]  rsp_b,
  output logic           carry_flag,
  output logic           busy,
  output logic [15:0]    retired
);

  state_t         state, state_nxt;
  kind_t          dec_kind, kind_q;
  logic [OPW-1:0] dec_op;
  logic [AW-1:0]  dec_ra, dec_rb, dec_rd, rd_q;
  logic           in_xfer;

  reg_alu_seq_decode u_decode (
    .word (in_data),
    .kind (dec_kind),
    .op   (dec_op),
    .ra   (dec_ra),
    .rb   (dec_rb),
    .rd   (dec_rd)
  );

  assign in_xfer = in_valid && in_ready;

  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (in_xfer) begin
          case (dec_kind)
            KIND_LOADI: state_nxt = S_IMM;
            KIND_ALU,
            KIND_READ:  state_nxt = S_EXEC;
            default:    state_nxt = S_IDLE;
          endcase
        end
      end
      S_IMM:   if (in_xfer) state_nxt = S_EXEC;
      S_EXEC:  state_nxt = (kind_q == KIND_READ) ? S_RSP : S_IDLE;
      S_RSP:   if (rsp_ready) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    in_ready  = !reset && (state == S_IDLE || state == S_IMM);
    busy      = (state != S_IDLE);
    rsp_valid = (state == S_RSP);
  end

  // reg_alu controls are loaded on the edge entering EXEC and cleared on the
  // next edge, so wr is a single-cycle pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      sel        <= 1'b0;
      wr         <= 1'b0;
      op         <= '0;
      rd_addr_a  <= '0;
      rd_addr_b  <= '0;
      wr_addr    <= '0;
      d_in       <= '0;
      kind_q     <= KIND_NOP;
      rd_q       <= '0;
      rsp_a      <= '0;
      rsp_b      <= '0;
      carry_flag <= 1'b0;
      retired    <= '0;
    end else begin
      sel       <= 1'b0;
      wr        <= 1'b0;
      op        <= '0;
      rd_addr_a <= '0;
      rd_addr_b <= '0;
      wr_addr   <= '0;
      d_in      <= '0;

      if (state == S_IDLE && in_xfer) begin
        kind_q <= dec_kind;
        rd_q   <= dec_rd;
        case (dec_kind)
          KIND_ALU: begin
            wr        <= 1'b1;
            sel       <= 1'b1;
            op        <= dec_op;
            rd_addr_a <= dec_ra;
            rd_addr_b <= dec_rb;
            wr_addr   <= dec_rd;
          end
          KIND_READ: begin
            rd_addr_a <= dec_ra;
            rd_addr_b <= dec_rb;
          end
          KIND_NOP: retired <= retired + 16'd1;
          default: ;
        endcase
      end

      if (state == S_IMM && in_xfer) begin
        wr      <= 1'b1;
        wr_addr <= rd_q;
        d_in    <= in_data;
      end

      if (state == S_EXEC) begin
        case (kind_q)
          KIND_ALU: begin
            carry_flag <= cout;
            retired    <= retired + 16'd1;
          end
          KIND_LOADI: retired <= retired + 16'd1;
          KIND_READ: begin
            rsp_a <= d_out_a;
            rsp_b <= d_out_b;
          end
          default: ;
        endcase
      end

      if (state == S_RSP && rsp_ready) retired <= retired + 16'd1;
    end
  end

endmodule
